hazard_pipe_tracker: RTL and testbench
======================================

// Module: hazard_pipe_tracker
// PURPOSE
//  Pipeline-register block for the D->E, E->M and M->W boundaries of the 5-stage MIPS core.
//  Carries each in-flight instruction's destination record (Rd, W, Tnew) plus PC/Instr.
//  Ages Tnew stage by stage and feeds the E/M records to the stall unit.
//  Consumes the stall unit's Pause: freezes PC/IF-ID and injects a bubble into E.
// PARAMETERS
//  PC_W    32  width of PC and instruction words
//  RA_W    5   register-address width
//  TNEW_W  2   width of Tnew / Tuse counters
// PORTS
//  clk          in   1       single clock, all regs on posedge
//  reset        in   1       synchronous, active-low; sampled on posedge clk
//  Pause_In     in   1       stall request from stall unit (combinational, same cycle)
//  PC_D_In      in   PC_W    PC of instruction in D
//  Instr_D_In   in   PC_W    instruction word in D
//  Rd_D_In      in   RA_W    decoded destination register in D
//  W_D_In       in   1       D instruction writes GPR
//  Tnew_D_In    in   TNEW_W  cycles from E-entry until result ready (0 = ready in E)
//  En_PC_Out    out  1       PC write enable = ~Pause_In
//  En_FD_Out    out  1       IF/ID register enable = ~Pause_In
//  PC_E_Out, Instr_E_Out, PC_M_Out, Instr_M_Out, PC_W_Out, Instr_W_Out  out  PC_W  per-stage copies
//  Rd_E_Out, Rd_M_Out, Rd_W_Out        out  RA_W    per-stage destination
//  W_E_Out, W_M_Out, W_W_Out           out  1       per-stage write flag
//  Tnew_E_Out, Tnew_M_Out              out  TNEW_W  per-stage remaining latency
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - All stage registers clear to 0, i.e. every stage holds a bubble.
//  - Reset has priority over Pause_In.
//  - En_PC_Out and En_FD_Out are combinational: 1 while Pause_In==0, including during reset.
//  D->E register, loaded every cycle:
//  - Pause_In==1: load bubble (PC, Instr, Rd, W, Tnew all 0).
//  - Pause_In==0: load D record.
//    - W_E <= W_D_In && (Rd_D_In != 0); writes to $0 never create hazards.
//    - Tnew_E <= Tnew_D_In.
//  E->M register, loaded every cycle, never stalled:
//  - Tnew_M <= (Tnew_E==0) ? 0 : Tnew_E-1 (saturating, no wrap).
//  - Rd, W, PC and Instr copied unchanged.
//  M->W register, loaded every cycle:
//  - Rd, W, PC and Instr copied unchanged.
//  - No Tnew at W; the result is always ready there.
//  - Any nonzero Tnew leaving M is a decode error; a sim-only assertion flags it.
//  Latency:
//  - A record accepted in D appears at E outputs 1 cycle later, M at 2, W at 3.
//  Consecutive Pause_In cycles:
//  - One bubble per cycle in E; older records keep draining to M/W.
//  - F/D stays frozen (externally) for the whole stall.
//  Pause_In high in the same cycle as reset: bubble results; the outputs are identical.
//  No combinational path from any *_In except Pause_In to any output; all other outputs are registered.
// STRUCTURE
//  - Shared header mips_defines.vh: TNEW_W, RA_W, PC_W, and Tnew encodings TNEW_0/1/2.
//    The decoder and stall unit use the same header.
//  - One sub-module, pipe_stage_reg:
//    - Holds one stage record {PC, Instr, Rd, W, Tnew}, with a sync active-low clear and a bubble input.
//    - Instantiated 3x, with the Tnew width unused at W.
//  - Tnew aging and the $0 masking live in the top level.
// TESTING
//  - Reset: hold reset=0 for 2 clks with random inputs -> all stage outputs 0; En_PC_Out=En_FD_Out=1.
//  - Flow: lw (Rd=8, W=1, Tnew=2) at D, Pause=0 -> E: Rd=8, Tnew=2; next clk M: Tnew=1; next clk W: Rd_W=8, W_W=1.
//  - Stall: Pause_In=1 for 2 cycles with add (Rd=9) held at D:
//    - En_PC_Out=En_FD_Out=0; E shows 2 consecutive bubbles (W_E=0, Rd_E=0).
//    - The lw ahead reaches M then W unchanged.
//    - On Pause_In=0 the add enters E.
//  - $0 masking: Rd_D=0, W_D=1 -> W_E_Out=0 one cycle later.
//  - Saturation: Tnew_D=0 -> Tnew_E=0, Tnew_M=0 (no wrap to 3).
//  - Reset mid-stall: Pause_In=1 and reset=0 on the same edge -> all stages 0.
//    - With reset released and Pause_In=0, the next D record loads normally.

Source files
------------

// File: rtl/hazard_pipe_tracker_pkg.sv
// Shared constants for the D/E/M/W pipeline-register slice of the MIPS core.
// Holds default widths and the Tnew encodings used by decoder and stall unit.
package hazard_pipe_tracker_pkg;

    // Default widths for PC/instruction words, register addresses and Tnew.
    localparam int PC_W_DEF   = 32;
    localparam int RA_W_DEF   = 5;
    localparam int TNEW_W_DEF = 2;

    // Tnew encodings: cycles from E-entry until the result is ready.
    typedef enum logic [TNEW_W_DEF-1:0] {
        TNEW_0 = 2'd0,
        TNEW_1 = 2'd1,
        TNEW_2 = 2'd2
    } tnew_e;

    // Largest Tnew that can still be ready by the time a record reaches W.
    localparam logic [TNEW_W_DEF-1:0] TNEW_MAX = TNEW_2;

endpackage

// File: rtl/hazard_pipe_tracker_pipe_stage_reg.sv
// One pipeline-stage record {PC, Instr, Rd, W, Tnew}, loaded every cycle.
// Ports: clk; rst_ni (sync active-low clear); bubble_i (load zeros);
//        pc_i/instr_i/rd_i/w_i/tnew_i record in; pc_o..tnew_o registered record out.
module pipe_stage_reg #(
    parameter int PC_W   = 32,
    parameter int RA_W   = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              bubble_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   instr_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic              w_i,
    input  logic [TNEW_W-1:0] tnew_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   instr_o,
    output logic [RA_W-1:0]   rd_o,
    output logic              w_o,
    output logic [TNEW_W-1:0] tnew_o
);

    logic [PC_W-1:0]   pc_d,    pc_q;
    logic [PC_W-1:0]   instr_d, instr_q;
    logic [RA_W-1:0]   rd_d,    rd_q;
    logic              w_d,     w_q;
    logic [TNEW_W-1:0] tnew_d,  tnew_q;

    // An all-zero record is a bubble: no write, no pending latency.
    always_comb begin
        pc_d    = pc_i;
        instr_d = instr_i;
        rd_d    = rd_i;
        w_d     = w_i;
        tnew_d  = tnew_i;
        if (bubble_i) begin
            pc_d    = '0;
            instr_d = '0;
            rd_d    = '0;
            w_d     = 1'b0;
            tnew_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            instr_q <= '0;
            rd_q    <= '0;
            w_q     <= 1'b0;
            tnew_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            w_q     <= w_d;
            tnew_q  <= tnew_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign rd_o    = rd_q;
    assign w_o     = w_q;
    assign tnew_o  = tnew_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// D->E, E->M, M->W pipeline registers carrying destination records for hazards.
// Ports: clk, reset (sync active-low), Pause_In; D record *_D_In; En_PC/En_FD;
//        per-stage PC/Instr/Rd/W outputs for E, M, W and Tnew for E, M.
module hazard_pipe_tracker
    import hazard_pipe_tracker_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Pause_In,
    input  logic [PC_W-1:0]   PC_D_In,
    input  logic [PC_W-1:0]   Instr_D_In,
    input  logic [RA_W-1:0]   Rd_D_In,
    input  logic              W_D_In,
    input  logic [TNEW_W-1:0] Tnew_D_In,
    output logic              En_PC_Out,
    output logic              En_FD_Out,
    output logic [PC_W-1:0]   PC_E_Out,
    output logic [PC_W-1:0]   Instr_E_Out,
    output logic [PC_W-1:0]   PC_M_Out,
    output logic [PC_W-1:0]   Instr_M_Out,
    output logic [PC_W-1:0]   PC_W_Out,
    output logic [PC_W-1:0]   Instr_W_Out,
    output logic [RA_W-1:0]   Rd_E_Out,
    output logic [RA_W-1:0]   Rd_M_Out,
    output logic [RA_W-1:0]   Rd_W_Out,
    output logic              W_E_Out,
    output logic              W_M_Out,
    output logic              W_W_Out,
    output logic [TNEW_W-1:0] Tnew_E_Out,
    output logic [TNEW_W-1:0] Tnew_M_Out
);

    logic              w_de;
    logic [TNEW_W-1:0] tnew_em;
    logic [TNEW_W-1:0] tnew_mw;
    logic [TNEW_W-1:0] tnew_w;

    // Stall only freezes fetch; the E bubble is injected below.
    assign En_PC_Out = ~Pause_In;
    assign En_FD_Out = ~Pause_In;

    // A write to $0 is architecturally dropped, so it never forwards.
    assign w_de = W_D_In && (Rd_D_In != '0);

    // Age by one stage, saturating at zero.
    assign tnew_em = (Tnew_E_Out == '0) ? '0 : Tnew_E_Out - 1'b1;
    assign tnew_mw = (Tnew_M_Out == '0) ? '0 : Tnew_M_Out - 1'b1;

    pipe_stage_reg #(
        .PC_W   (PC_W),
        .RA_W   (RA_W),
        .TNEW_W (TNEW_W)
    ) u_de (
        .clk      (clk),
        .rst_ni   (reset),
        .bubble_i (Pause_In),
        .pc_i     (PC_D_In),
        .instr_i  (Instr_D_In),
        .rd_i     (Rd_D_In),
        .w_i      (w_de),
        .tnew_i   (Tnew_D_In),
        .pc_o     (PC_E_Out),
        .instr_o  (Instr_E_Out),
        .rd_o     (Rd_E_Out),
        .w_o      (W_E_Out),
        .tnew_o   (Tnew_E_Out)
    );

    pipe_stage_reg #(
        .PC_W   (PC_W),
        .RA_W   (RA_W),
        .TNEW_W (TNEW_W)
    ) u_em (
        .clk      (clk),
        .rst_ni   (reset),
        .bubble_i (1'b0),
        .pc_i     (PC_E_Out),
        .instr_i  (Instr_E_Out),
        .rd_i     (Rd_E_Out),
        .w_i      (W_E_Out),
        .tnew_i   (tnew_em),
        .pc_o     (PC_M_Out),
        .instr_o  (Instr_M_Out),
        .rd_o     (Rd_M_Out),
        .w_o      (W_M_Out),
        .tnew_o   (Tnew_M_Out)
    );

    // The W copy of Tnew is kept only so a leftover latency can be caught.
    pipe_stage_reg #(
        .PC_W   (PC_W),
        .RA_W   (RA_W),
        .TNEW_W (TNEW_W)
    ) u_mw (
        .clk      (clk),
        .rst_ni   (reset),
        .bubble_i (1'b0),
        .pc_i     (PC_M_Out),
        .instr_i  (Instr_M_Out),
        .rd_i     (Rd_M_Out),
        .w_i      (W_M_Out),
        .tnew_i   (tnew_mw),
        .pc_o     (PC_W_Out),
        .instr_o  (Instr_W_Out),
        .rd_o     (Rd_W_Out),
        .w_o      (W_W_Out),
        .tnew_o   (tnew_w)
    );

`ifndef SYNTHESIS
    // A result still pending at W means the decoder produced an illegal Tnew.
    a_tnew_w_zero : assert property (@(posedge clk) tnew_w == '0);
`endif

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Scoreboard bench for hazard_pipe_tracker: random and directed D records.
// Reference model is a history of records entering E, aged by arithmetic.
module tb_hazard_pipe_tracker;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        w;
        logic [1:0]  tnew;
    } rec_t;

    typedef struct {
        rec_t e;
        rec_t m;
        rec_t w;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Pause_In;
    logic [31:0] PC_D_In;
    logic [31:0] Instr_D_In;
    logic [4:0]  Rd_D_In;
    logic        W_D_In;
    logic [1:0]  Tnew_D_In;
    logic        En_PC_Out;
    logic        En_FD_Out;
    logic [31:0] PC_E_Out, Instr_E_Out;
    logic [31:0] PC_M_Out, Instr_M_Out;
    logic [31:0] PC_W_Out, Instr_W_Out;
    logic [4:0]  Rd_E_Out, Rd_M_Out, Rd_W_Out;
    logic        W_E_Out, W_M_Out, W_W_Out;
    logic [1:0]  Tnew_E_Out, Tnew_M_Out;

    int n_cmp = 0;
    int n_bad = 0;

    rec_t  hist[$];
    snap_t sbq[$];
    rec_t  bub;

    always #5 clk = ~clk;

    hazard_pipe_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .Pause_In    (Pause_In),
        .PC_D_In     (PC_D_In),
        .Instr_D_In  (Instr_D_In),
        .Rd_D_In     (Rd_D_In),
        .W_D_In      (W_D_In),
        .Tnew_D_In   (Tnew_D_In),
        .En_PC_Out   (En_PC_Out),
        .En_FD_Out   (En_FD_Out),
        .PC_E_Out    (PC_E_Out),
        .Instr_E_Out (Instr_E_Out),
        .PC_M_Out    (PC_M_Out),
        .Instr_M_Out (Instr_M_Out),
        .PC_W_Out    (PC_W_Out),
        .Instr_W_Out (Instr_W_Out),
        .Rd_E_Out    (Rd_E_Out),
        .Rd_M_Out    (Rd_M_Out),
        .Rd_W_Out    (Rd_W_Out),
        .W_E_Out     (W_E_Out),
        .W_M_Out     (W_M_Out),
        .W_W_Out     (W_W_Out),
        .Tnew_E_Out  (Tnew_E_Out),
        .Tnew_M_Out  (Tnew_M_Out)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                input logic [4:0] rd, input logic w,
                                input logic [1:0] t);
        rec_t r;
        r.pc = pc; r.instr = ins; r.rd = rd; r.w = w; r.tnew = t;
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc    = $urandom;
        r.instr = $urandom;
        r.rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        r.w     = 1'($urandom);
        r.tnew  = 2'($urandom_range(0, 2));
        return r;
    endfunction

    // Apply one cycle of stimulus, then record what E/M/W must show after it.
    task automatic step(input logic rstn, input logic p, input rec_t d);
        rec_t  ent;
        snap_t s;
        int    n;
        reset      = rstn;
        Pause_In   = p;
        PC_D_In    = d.pc;
        Instr_D_In = d.instr;
        Rd_D_In    = d.rd;
        W_D_In     = d.w;
        Tnew_D_In  = d.tnew;
        #1;
        chk("En_PC", 32'(En_PC_Out), 32'(!p));
        chk("En_FD", 32'(En_FD_Out), 32'(!p));
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < 3; i++) hist.push_back(bub);
        end else if (p) begin
            hist.push_back(bub);
        end else begin
            ent = d;
            ent.w = d.w && (d.rd != 5'd0);
            hist.push_back(ent);
        end
        while (hist.size() > 3) void'(hist.pop_front());
        n = hist.size();
        s.e = hist[n-1];
        s.m = hist[n-2];
        s.m.tnew = (int'(hist[n-2].tnew) > 0) ? hist[n-2].tnew - 2'd1 : 2'd0;
        s.w = hist[n-3];
        s.w.tnew = 2'd0;
        sbq.push_back(s);
        #1;
    endtask

    // Monitor: every negedge after an edge has been modelled, compare outputs.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                s = sbq.pop_front();
                chk("PC_E",    PC_E_Out,          s.e.pc);
                chk("Instr_E", Instr_E_Out,       s.e.instr);
                chk("Rd_E",    32'(Rd_E_Out),     32'(s.e.rd));
                chk("W_E",     32'(W_E_Out),      32'(s.e.w));
                chk("Tnew_E",  32'(Tnew_E_Out),   32'(s.e.tnew));
                chk("PC_M",    PC_M_Out,          s.m.pc);
                chk("Instr_M", Instr_M_Out,       s.m.instr);
                chk("Rd_M",    32'(Rd_M_Out),     32'(s.m.rd));
                chk("W_M",     32'(W_M_Out),      32'(s.m.w));
                chk("Tnew_M",  32'(Tnew_M_Out),   32'(s.m.tnew));
                chk("PC_W",    PC_W_Out,          s.w.pc);
                chk("Instr_W", Instr_W_Out,       s.w.instr);
                chk("Rd_W",    32'(Rd_W_Out),     32'(s.w.rd));
                chk("W_W",     32'(W_W_Out),      32'(s.w.w));
            end
        end
    end

    initial begin
        rec_t lw;
        rec_t add;
        rec_t nop;
        bub = mk(32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
        nop = mk(32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) hist.push_back(bub);
        lw  = mk(32'h0000_3000, 32'h8c08_0000, 5'd8, 1'b1, 2'd2);
        add = mk(32'h0000_3004, 32'h0109_4820, 5'd9, 1'b1, 2'd1);

        @(posedge clk);
        #1;
        // Reset with random inputs, including Pause.
        step(1'b0, 1'b0, rnd_rec());
        step(1'b0, 1'b1, rnd_rec());

        // lw flows E -> M -> W, then add stalled two cycles behind it.
        step(1'b1, 1'b0, lw);
        step(1'b1, 1'b1, add);
        step(1'b1, 1'b1, add);
        step(1'b1, 1'b0, add);
        step(1'b1, 1'b0, nop);
        step(1'b1, 1'b0, nop);
        step(1'b1, 1'b0, nop);

        // $0 write masked; Tnew of 0 saturates.
        step(1'b1, 1'b0, mk(32'h0000_3008, 32'h0000_0020, 5'd0, 1'b1, 2'd2));
        step(1'b1, 1'b0, mk(32'h0000_300c, 32'h0000_1020, 5'd3, 1'b1, 2'd0));
        step(1'b1, 1'b0, nop);
        step(1'b1, 1'b0, nop);

        // Reset and Pause on the same edge mid-stall, then a normal load.
        step(1'b1, 1'b0, lw);
        step(1'b1, 1'b1, add);
        step(1'b0, 1'b1, add);
        step(1'b1, 1'b0, add);
        step(1'b1, 1'b0, nop);

        // Random traffic with occasional stalls and resets.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0),
                 rnd_rec());
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
